axi4_rd_arbiter_2to1: RTL and testbench
=======================================

Name: axi4_rd_arbiter_2to1

Overview:
Two-requester AXI4 read-channel arbiter sharing one AXI4 slave port, which in the team's benches is the QVIP/XRTL slave wrapper. It round-robins AR requests from masters 0 and 1 into a registered AR output and extends ARID by one MSB carrying the master index. It steers R beats back using that RID MSB and tracks outstanding bursts per master.

Parameters:
ADDR_WIDTH, 32, AR address width
ID_WIDTH, 4, master-side ID width; slave-side ID is ID_WIDTH+1
RDATA_WIDTH, 32, read data width
MAX_OUTSTANDING, 4, max unfinished bursts per master (≥1)

Ports:
ACLK  in  1  clock
ARESET  in  1  async reset, active-high
mX_arvalid  in  1  AR valid from master X (X=0,1)
mX_araddr  in  ADDR_WIDTH  AR address
mX_arlen  in  8  burst length-1
mX_arsize  in  3  beat size
mX_arburst  in  2  burst type
mX_arid  in  ID_WIDTH  AR ID
mX_arready  out  1  AR accept to master X
mX_rvalid  out  1  R valid to master X
mX_rdata  out  RDATA_WIDTH  R data (shared fan-out)
mX_rresp  out  2  R response
mX_rlast  out  1  last beat
mX_rid  out  ID_WIDTH  RID with MSB stripped
mX_rready  in  1  R ready from master X
s_arvalid/s_araddr/s_arlen/s_arsize/s_arburst  out  1/ADDR_WIDTH/8/3/2  registered AR to slave
s_arid  out  ID_WIDTH+1  {grant_idx, mX_arid}
s_arready  in  1  slave AR ready
s_rvalid/s_rdata/s_rresp/s_rlast  in  1/RDATA_WIDTH/2/1  R from slave
s_rid  in  ID_WIDTH+1  RID; MSB selects master
s_rready  out  1  R ready to slave
err_unexp_r  out  1  one-cycle pulse: RLAST beat for a master with zero outstanding bursts

Behaviour:
- All registers clear asynchronously on ARESET=1. At reset: s_arvalid=0, s_ar* payload=0, err_unexp_r=0, counters=0, state=IDLE, last_grant=1, so master 0 has first priority.
- AR FSM has two states: IDLE and HOLD.
- IDLE: a master is eligible if mX_arvalid=1 and cnt[X]<MAX_OUTSTANDING. If both are eligible, the master ≠ last_grant wins; otherwise the sole eligible master wins. Winner's mX_arready=1 combinationally and the loser's is 0. On the handshake: latch payload and s_arid={X,mX_arid}, set last_grant=X, cnt[X]++, go to HOLD.
- HOLD: s_arvalid=1, all mX_arready=0, payload stable. On s_arready=1: s_arvalid=0 the next cycle and return to IDLE.
- AR latency is 1 cycle from master handshake to s_arvalid. Peak throughput is one AR per 2 cycles. No combinational path from s_arready to mX_arready.
- Eligibility gate: a master with cnt=MAX_OUTSTANDING never sees arready, even if it is the only requester.
- R path is purely combinational, with no buffering. sel=s_rid[ID_WIDTH].
  - m[sel]_rvalid=s_rvalid; the other master's rvalid=0.
  - s_rready=m[sel]_rready.
  - mX_rid=s_rid[ID_WIDTH-1:0]; rdata, rresp and rlast fan out to both masters.
- Counter decrement: on s_rvalid & s_rready & s_rlast, cnt[sel]--.
  - Simultaneous increment and decrement on the same master: cnt unchanged.
  - Decrement when cnt[sel]=0: cnt stays 0 and err_unexp_r pulses 1 in the next cycle.
- Counter width is $clog2(MAX_OUTSTANDING+1). No wrap: increments are blocked at the limit and decrements saturate at 0.
- ARESET asserted mid-burst or during HOLD: the pending AR is dropped (s_arvalid→0 immediately) and counters clear. Masters must also be reset.

Test Plan:
- Reset, then m0_arvalid with araddr=0x1000, arid=3 → m0_arready=1 in the same cycle. The next cycle gives s_arvalid=1, s_araddr=0x1000, s_arid=5'b0_0011. With s_arready=1 that cycle, s_arvalid=0 one cycle later.
- m0 and m1 both valid continuously with s_arready=1 → grants alternate m0,m1,m0,m1 with one AR every 2 cycles, and s_arid MSB alternates 0,1,0,1.
- HOLD with s_arready=0 for 5 cycles → s_arvalid and payload stable for 5 cycles, and both mX_arready=0 throughout.
- m1 issues 4 ARs with no R returned (MAX_OUTSTANDING=4) → the 5th m1 request is never granted while m0 requests still win. One R beat with s_rid MSB=1 and rlast=1 → m1 is granted on the next IDLE.
- Slave R with s_rid=5'b1_0110 and rlast=0 then 1 → m1_rvalid=1, m1_rid=4'b0110, m0_rvalid=0, and s_rready follows m1_rready. cnt[1] decrements only on the rlast beat.
- RLAST beat with s_rid MSB=0 while cnt[0]=0 → err_unexp_r=1 for exactly one cycle and cnt[0] stays 0.
- ARESET=1 during HOLD → s_arvalid=0 and counters=0 asynchronously. After release, master 0 has priority.

Source files
------------

// File: rtl/axi4_rd_arbiter_2to1.sv
// Two-master AXI4 read arbiter: round-robin AR into one registered slave AR,
// RID MSB carries the master index and steers R beats back combinationally.
module axi4_rd_arbiter_2to1 #(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int RDATA_WIDTH     = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  // master 0
  input  logic                   m0_arvalid,
  input  logic [ADDR_WIDTH-1:0]  m0_araddr,
  input  logic [7:0]             m0_arlen,
  input  logic [2:0]             m0_arsize,
  input  logic [1:0]             m0_arburst,
  input  logic [ID_WIDTH-1:0]    m0_arid,
  output logic                   m0_arready,
  output logic                   m0_rvalid,
  output logic [RDATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]             m0_rresp,
  output logic                   m0_rlast,
  output logic [ID_WIDTH-1:0]    m0_rid,
  input  logic                   m0_rready,
  // master 1
  input  logic                   m1_arvalid,
  input  logic [ADDR_WIDTH-1:0]  m1_araddr,
  input  logic [7:0]             m1_arlen,
  input  logic [2:0]             m1_arsize,
  input  logic [1:0]             m1_arburst,
  input  logic [ID_WIDTH-1:0]    m1_arid,
  output logic                   m1_arready,
  output logic                   m1_rvalid,
  output logic [RDATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]             m1_rresp,
  output logic                   m1_rlast,
  output logic [ID_WIDTH-1:0]    m1_rid,
  input  logic                   m1_rready,
  // slave
  output logic                   s_arvalid,
  output logic [ADDR_WIDTH-1:0]  s_araddr,
  output logic [7:0]             s_arlen,
  output logic [2:0]             s_arsize,
  output logic [1:0]             s_arburst,
  output logic [ID_WIDTH:0]      s_arid,
  input  logic                   s_arready,
  input  logic                   s_rvalid,
  input  logic [RDATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]             s_rresp,
  input  logic                   s_rlast,
  input  logic [ID_WIDTH:0]      s_rid,
  output logic                   s_rready,
  output logic                   err_unexp_r
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t state_reg, state_next;
  logic   last_grant_reg, last_grant_next;
  logic   winner;
  logic   ar_hs;

  logic [1:0]                  arvalid_vec;
  logic [1:0][ADDR_WIDTH-1:0]  araddr_vec;
  logic [1:0][7:0]             arlen_vec;
  logic [1:0][2:0]             arsize_vec;
  logic [1:0][1:0]             arburst_vec;
  logic [1:0][ID_WIDTH-1:0]    arid_vec;

  logic [1:0]                  eligible;
  logic [1:0]                  inc;
  logic [1:0]                  dec;
  logic [1:0]                  unexp;
  logic [1:0][CNT_W-1:0]       cnt_vec;

  logic                        r_sel;
  logic                        r_done;
  logic                        err_reg;

  logic [ADDR_WIDTH-1:0]       s_araddr_reg;
  logic [7:0]                  s_arlen_reg;
  logic [2:0]                  s_arsize_reg;
  logic [1:0]                  s_arburst_reg;
  logic [ID_WIDTH:0]           s_arid_reg;

  assign arvalid_vec = {m1_arvalid, m0_arvalid};
  assign araddr_vec  = {m1_araddr, m0_araddr};
  assign arlen_vec   = {m1_arlen, m0_arlen};
  assign arsize_vec  = {m1_arsize, m0_arsize};
  assign arburst_vec = {m1_arburst, m0_arburst};
  assign arid_vec    = {m1_arid, m0_arid};

  // R steering: the RID MSB names the master that owns the beat
  assign r_sel  = s_rid[ID_WIDTH];
  assign r_done = s_rvalid && s_rready && s_rlast;

  // Per-master outstanding-burst counters and eligibility
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      logic [CNT_W-1:0] cnt_reg;

      assign eligible[gi] = arvalid_vec[gi] && (cnt_reg < CNT_MAX);
      assign inc[gi]      = ar_hs && (winner == 1'(gi));
      assign dec[gi]      = r_done && (r_sel == 1'(gi));
      assign unexp[gi]    = dec[gi] && (cnt_reg == '0);
      assign cnt_vec[gi]  = cnt_reg;

      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          cnt_reg <= '0;
        end else if (inc[gi] && !dec[gi]) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end else if (dec[gi] && !inc[gi] && (cnt_reg != '0)) begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end
    end
  endgenerate

  // AR arbitration: grant only from IDLE so s_arready never reaches mX_arready
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    winner          = 1'b0;
    ar_hs           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          ar_hs           = 1'b1;
          winner          = (&eligible) ? ~last_grant_reg : eligible[1];
          last_grant_next = winner;
          state_next      = HOLD;
        end
      end
      HOLD: begin
        if (s_arready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s_araddr_reg  <= '0;
      s_arlen_reg   <= '0;
      s_arsize_reg  <= '0;
      s_arburst_reg <= '0;
      s_arid_reg    <= '0;
    end else if (ar_hs) begin
      s_araddr_reg  <= araddr_vec[winner];
      s_arlen_reg   <= arlen_vec[winner];
      s_arsize_reg  <= arsize_vec[winner];
      s_arburst_reg <= arburst_vec[winner];
      s_arid_reg    <= {winner, arid_vec[winner]};
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= |unexp;
    end
  end

  assign m0_arready  = ar_hs && !winner;
  assign m1_arready  = ar_hs && winner;

  assign s_arvalid   = (state_reg == HOLD);
  assign s_araddr    = s_araddr_reg;
  assign s_arlen     = s_arlen_reg;
  assign s_arsize    = s_arsize_reg;
  assign s_arburst   = s_arburst_reg;
  assign s_arid      = s_arid_reg;

  assign m0_rvalid   = s_rvalid && !r_sel;
  assign m1_rvalid   = s_rvalid && r_sel;
  assign s_rready    = r_sel ? m1_rready : m0_rready;
  assign m0_rdata    = s_rdata;
  assign m1_rdata    = s_rdata;
  assign m0_rresp    = s_rresp;
  assign m1_rresp    = s_rresp;
  assign m0_rlast    = s_rlast;
  assign m1_rlast    = s_rlast;
  assign m0_rid      = s_rid[ID_WIDTH-1:0];
  assign m1_rid      = s_rid[ID_WIDTH-1:0];

  assign err_unexp_r = err_reg;

endmodule

// File: tb/tb_axi4_rd_arbiter_2to1.sv
// Bench for axi4_rd_arbiter_2to1: directed scenarios plus a randomized run
// scored against a rule-level model of grants, outstanding counts and R steering.
module tb_axi4_rd_arbiter_2to1;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        m0_arvalid, m1_arvalid;
  logic [31:0] m0_araddr, m1_araddr;
  logic [7:0]  m0_arlen, m1_arlen;
  logic [2:0]  m0_arsize, m1_arsize;
  logic [1:0]  m0_arburst, m1_arburst;
  logic [3:0]  m0_arid, m1_arid;
  logic        m0_arready, m1_arready;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rlast, m1_rlast;
  logic [3:0]  m0_rid, m1_rid;
  logic        m0_rready, m1_rready;
  logic        s_arvalid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [4:0]  s_arid;
  logic        s_arready;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [4:0]  s_rid;
  logic        s_rready;
  logic        err_unexp_r;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  axi4_rd_arbiter_2to1 #(
    .ADDR_WIDTH(32), .ID_WIDTH(4), .RDATA_WIDTH(32), .MAX_OUTSTANDING(4)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arid(m0_arid),
    .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arid(m1_arid),
    .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid), .m1_rready(m1_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid), .s_rready(s_rready),
    .err_unexp_r(err_unexp_r)
  );

  task automatic idle_inputs();
    m0_arvalid = 0; m0_araddr = 0; m0_arlen = 0; m0_arsize = 0; m0_arburst = 0; m0_arid = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_arlen = 0; m1_arsize = 0; m1_arburst = 0; m1_arid = 0;
    m0_rready = 0; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 0;
  endtask

  // Leaves the bench at a falling edge with reset released and the DUT idle
  task automatic apply_reset();
    ARESET = 1'b1;
    idle_inputs();
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  // Issues n back-to-back ARs from one master with an always-ready slave
  task automatic fill_m(input int m, input int n);
    if (m == 0) m0_arvalid = 1; else m1_arvalid = 1;
    s_arready = 1;
    repeat (2 * n) @(negedge ACLK);
    m0_arvalid = 0; m1_arvalid = 0; s_arready = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid: got %b want 0", s_arvalid); end
    total++; if (s_araddr !== 32'h0) begin bad++; $display("FAIL reset_araddr: got %h want 0", s_araddr); end
    total++; if (s_arid !== 5'h0) begin bad++; $display("FAIL reset_arid: got %h want 0", s_arid); end
    total++; if (err_unexp_r !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_unexp_r); end
    total++; if (m0_arready !== 1'b0 || m1_arready !== 1'b0) begin bad++; $display("FAIL reset_arready_idle: got %b%b want 00", m1_arready, m0_arready); end
    m0_arvalid = 1; m1_arvalid = 1;
    #1;
    total++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin bad++; $display("FAIL reset_first_priority: got m1/m0=%b%b want 01", m1_arready, m0_arready); end
    m0_arvalid = 0; m1_arvalid = 0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    apply_reset();
    m0_arvalid = 1; m0_araddr = 32'h1000; m0_arid = 4'd3; m0_arlen = 8'd7; m0_arsize = 3'd2; m0_arburst = 2'd1;
    #1;
    total++; if (m0_arready !== 1'b1) begin bad++; $display("FAIL single_arready: got %b want 1", m0_arready); end
    @(negedge ACLK);
    m0_arvalid = 0;
    #1;
    total++; if (s_arvalid !== 1'b1) begin bad++; $display("FAIL single_arvalid: got %b want 1", s_arvalid); end
    total++; if (s_araddr !== 32'h1000) begin bad++; $display("FAIL single_araddr: got %h want 1000", s_araddr); end
    total++; if (s_arid !== 5'b0_0011) begin bad++; $display("FAIL single_arid: got %b want 00011", s_arid); end
    total++; if (s_arlen !== 8'd7 || s_arsize !== 3'd2 || s_arburst !== 2'd1) begin bad++; $display("FAIL single_payload: got len=%0d size=%0d burst=%0d want 7 2 1", s_arlen, s_arsize, s_arburst); end
    s_arready = 1;
    @(negedge ACLK);
    s_arready = 0;
    #1;
    total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL single_arvalid_drop: got %b want 0", s_arvalid); end
    $display("test_single done: ar addr=%h id=%b", 32'h1000, 5'b0_0011);
  endtask

  task automatic test_alternate();
    apply_reset();
    m0_arvalid = 1; m0_araddr = 32'hA000; m0_arid = 4'h1;
    m1_arvalid = 1; m1_araddr = 32'hB000; m1_arid = 4'h2;
    s_arready = 1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (c % 2 == 0) begin
        total++;
        if (s_arvalid !== 1'b0 || m0_arready !== ((c / 2) % 2 == 0) || m1_arready !== ((c / 2) % 2 == 1)) begin
          bad++; $display("FAIL alt_grant c=%0d: got arvalid=%b m1/m0=%b%b want 0 m%0d", c, s_arvalid, m1_arready, m0_arready, (c / 2) % 2);
        end
      end else begin
        total++;
        if (s_arvalid !== 1'b1 || s_arid[4] !== 1'((c / 2) % 2)) begin
          bad++; $display("FAIL alt_ar c=%0d: got arvalid=%b msb=%b want 1 %0d", c, s_arvalid, s_arid[4], (c / 2) % 2);
        end else begin
          $display("alt ar issued: m%0d addr=%h", s_arid[4], s_araddr);
        end
      end
      @(negedge ACLK);
    end
    #1;
    total++; if (m0_arready !== 1'b0 || m1_arready !== 1'b0) begin bad++; $display("FAIL alt_both_full: got m1/m0=%b%b want 00", m1_arready, m0_arready); end
    m0_arvalid = 0; m1_arvalid = 0; s_arready = 0;
  endtask

  task automatic test_hold_stall();
    apply_reset();
    m1_arvalid = 1; m1_araddr = 32'h2222; m1_arid = 4'h9; m1_arlen = 8'd3;
    #1;
    total++; if (m1_arready !== 1'b1) begin bad++; $display("FAIL stall_grant: got %b want 1", m1_arready); end
    @(negedge ACLK);
    m0_arvalid = 1; m0_araddr = 32'h5555;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (s_arvalid !== 1'b1 || s_araddr !== 32'h2222 || s_arid !== 5'b1_1001 || s_arlen !== 8'd3) begin
        bad++; $display("FAIL stall_payload i=%0d: got v=%b a=%h id=%b len=%0d want 1 2222 11001 3", i, s_arvalid, s_araddr, s_arid, s_arlen);
      end
      total++;
      if (m0_arready !== 1'b0 || m1_arready !== 1'b0) begin
        bad++; $display("FAIL stall_arready i=%0d: got m1/m0=%b%b want 00", i, m1_arready, m0_arready);
      end
      @(negedge ACLK);
    end
    s_arready = 1;
    #1;
    total++; if (s_arvalid !== 1'b1) begin bad++; $display("FAIL stall_accept: got %b want 1", s_arvalid); end
    @(negedge ACLK);
    m0_arvalid = 0; m1_arvalid = 0; s_arready = 0;
    #1;
    total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL stall_release: got %b want 0", s_arvalid); end
    $display("test_hold_stall done");
  endtask

  task automatic test_limit();
    int grants;
    apply_reset();
    fill_m(1, 4);
    m0_arvalid = 1; m1_arvalid = 1; s_arready = 1;
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++; if (m1_arready !== 1'b0) begin bad++; $display("FAIL limit_m1_blocked c=%0d: got %b want 0", c, m1_arready); end
      if (m0_arready === 1'b1) grants++;
      @(negedge ACLK);
    end
    total++; if (grants != 3) begin bad++; $display("FAIL limit_m0_grants: got %0d want 3", grants); end
    m0_arvalid = 0;
    #1;
    total++; if (m1_arready !== 1'b0) begin bad++; $display("FAIL limit_sole_blocked: got %b want 0", m1_arready); end
    s_rvalid = 1; s_rid = 5'h10; s_rlast = 1; m1_rready = 1;
    #1;
    total++; if (s_rready !== 1'b1 || m1_rvalid !== 1'b1) begin bad++; $display("FAIL limit_r_beat: got rready=%b m1_rvalid=%b want 1 1", s_rready, m1_rvalid); end
    @(negedge ACLK);
    s_rvalid = 0; s_rlast = 0; m1_rready = 0;
    #1;
    total++; if (m1_arready !== 1'b1) begin bad++; $display("FAIL limit_m1_freed: got %b want 1", m1_arready); end
    m1_arvalid = 0; s_arready = 0;
    $display("test_limit done: m0 grants=%0d", grants);
  endtask

  task automatic test_r_steer();
    logic [31:0] d;
    apply_reset();
    fill_m(1, 4);
    d = $urandom;
    s_rvalid = 1; s_rid = 5'b1_0110; s_rlast = 0; s_rdata = d; s_rresp = 2'b10;
    m1_rready = 1; m0_rready = 0;
    #1;
    total++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0) begin bad++; $display("FAIL steer_rvalid: got m1/m0=%b%b want 10", m1_rvalid, m0_rvalid); end
    total++; if (m1_rid !== 4'b0110) begin bad++; $display("FAIL steer_rid: got %b want 0110", m1_rid); end
    total++; if (m1_rdata !== d || m0_rdata !== d || m1_rresp !== 2'b10) begin bad++; $display("FAIL steer_data: got %h/%h resp=%b want %h 10", m1_rdata, m0_rdata, m1_rresp, d); end
    total++; if (s_rready !== 1'b1) begin bad++; $display("FAIL steer_rready_hi: got %b want 1", s_rready); end
    @(negedge ACLK);
    s_rlast = 1; m1_rready = 0; m0_rready = 1; m1_arvalid = 1;
    #1;
    total++; if (s_rready !== 1'b0) begin bad++; $display("FAIL steer_rready_lo: got %b want 0", s_rready); end
    total++; if (m1_arready !== 1'b0 || m1_rlast !== 1'b1) begin bad++; $display("FAIL steer_nonlast_kept: got arready=%b rlast=%b want 0 1", m1_arready, m1_rlast); end
    @(negedge ACLK);
    m1_rready = 1;
    #1;
    total++; if (m1_arready !== 1'b0) begin bad++; $display("FAIL steer_before_dec: got %b want 0", m1_arready); end
    @(negedge ACLK);
    s_rvalid = 0; s_rlast = 0; m1_rready = 0; m0_rready = 0;
    #1;
    total++; if (m1_arready !== 1'b1) begin bad++; $display("FAIL steer_after_dec: got %b want 1", m1_arready); end
    m1_arvalid = 0;
    $display("test_r_steer done: data=%h", d);
  endtask

  task automatic test_unexp_r();
    apply_reset();
    s_rvalid = 1; s_rid = 5'b0_0101; s_rlast = 1; m0_rready = 1;
    #1;
    total++; if (err_unexp_r !== 1'b0) begin bad++; $display("FAIL unexp_early: got %b want 0", err_unexp_r); end
    @(negedge ACLK);
    s_rvalid = 0; s_rlast = 0; m0_rready = 0;
    #1;
    total++; if (err_unexp_r !== 1'b1) begin bad++; $display("FAIL unexp_pulse: got %b want 1", err_unexp_r); end
    @(negedge ACLK);
    #1;
    total++; if (err_unexp_r !== 1'b0) begin bad++; $display("FAIL unexp_one_cycle: got %b want 0", err_unexp_r); end
    m0_arvalid = 1;
    #1;
    total++; if (m0_arready !== 1'b1) begin bad++; $display("FAIL unexp_cnt_zero: got %b want 1", m0_arready); end
    m0_arvalid = 0;
    @(negedge ACLK);
    fill_m(0, 4);
    m0_arvalid = 1;
    #1;
    total++; if (m0_arready !== 1'b0) begin bad++; $display("FAIL unexp_cnt_saturated: got %b want 0", m0_arready); end
    m0_arvalid = 0;
    $display("test_unexp_r done");
  endtask

  task automatic test_reset_in_hold();
    apply_reset();
    fill_m(1, 4);
    m0_arvalid = 1; m0_araddr = 32'h7777;
    @(negedge ACLK);
    m0_arvalid = 0;
    #1;
    total++; if (s_arvalid !== 1'b1) begin bad++; $display("FAIL rsthold_in_hold: got %b want 1", s_arvalid); end
    #1 ARESET = 1'b1;
    #1;
    total++; if (s_arvalid !== 1'b0 || s_araddr !== 32'h0 || s_arid !== 5'h0) begin bad++; $display("FAIL rsthold_async: got v=%b a=%h id=%h want 0 0 0", s_arvalid, s_araddr, s_arid); end
    @(negedge ACLK);
    ARESET = 1'b0;
    m0_arvalid = 1; m1_arvalid = 1;
    #1;
    total++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin bad++; $display("FAIL rsthold_priority: got m1/m0=%b%b want 01", m1_arready, m0_arready); end
    m0_arvalid = 0;
    #1;
    total++; if (m1_arready !== 1'b1) begin bad++; $display("FAIL rsthold_cnt_cleared: got %b want 1", m1_arready); end
    m1_arvalid = 0;
    $display("test_reset_in_hold done");
  endtask

  task automatic test_random();
    int  cnt[2];
    int  last, g, sel;
    bit  hold, err_exp, exp_rready, done;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    logic [2:0]  exp_size;
    logic [1:0]  exp_burst;
    logic [4:0]  exp_id;
    apply_reset();
    cnt[0] = 0; cnt[1] = 0; last = 1; hold = 0; err_exp = 0;
    exp_addr = 0; exp_len = 0; exp_size = 0; exp_burst = 0; exp_id = 0;
    for (int c = 0; c < 600; c++) begin
      m0_arvalid = ($urandom_range(0, 9) < 6); m0_araddr = $urandom; m0_arid = 4'($urandom);
      m0_arlen = 8'($urandom); m0_arsize = 3'($urandom); m0_arburst = 2'($urandom);
      m1_arvalid = ($urandom_range(0, 9) < 6); m1_araddr = $urandom; m1_arid = 4'($urandom);
      m1_arlen = 8'($urandom); m1_arsize = 3'($urandom); m1_arburst = 2'($urandom);
      s_arready = ($urandom_range(0, 3) != 0);
      s_rvalid = ($urandom_range(0, 2) == 0);
      s_rid = 5'($urandom); s_rlast = ($urandom_range(0, 2) != 0); s_rdata = $urandom; s_rresp = 2'($urandom);
      m0_rready = ($urandom_range(0, 3) != 0); m1_rready = ($urandom_range(0, 3) != 0);
      #1;
      // Expected grant from the arbitration rules
      g = -1;
      if (!hold) begin
        if (m0_arvalid && cnt[0] < 4 && m1_arvalid && cnt[1] < 4) g = (last == 0) ? 1 : 0;
        else if (m0_arvalid && cnt[0] < 4) g = 0;
        else if (m1_arvalid && cnt[1] < 4) g = 1;
      end
      sel = int'(s_rid[4]);
      exp_rready = (sel == 1) ? m1_rready : m0_rready;
      total++; if (s_arvalid !== hold) begin bad++; $display("FAIL rnd_arvalid c=%0d: got %b want %b", c, s_arvalid, hold); end
      if (hold) begin
        total++;
        if ({s_araddr, s_arlen, s_arsize, s_arburst, s_arid} !== {exp_addr, exp_len, exp_size, exp_burst, exp_id}) begin
          bad++; $display("FAIL rnd_payload c=%0d: got a=%h l=%h id=%h want a=%h l=%h id=%h", c, s_araddr, s_arlen, s_arid, exp_addr, exp_len, exp_id);
        end
      end
      total++; if (m0_arready !== (g == 0) || m1_arready !== (g == 1)) begin bad++; $display("FAIL rnd_arready c=%0d: got m1/m0=%b%b want grant %0d", c, m1_arready, m0_arready, g); end
      total++; if (err_unexp_r !== err_exp) begin bad++; $display("FAIL rnd_err c=%0d: got %b want %b", c, err_unexp_r, err_exp); end
      total++;
      if (m0_rvalid !== (s_rvalid && sel == 0) || m1_rvalid !== (s_rvalid && sel == 1) || s_rready !== exp_rready || m0_rid !== s_rid[3:0] || m1_rid !== s_rid[3:0]) begin
        bad++; $display("FAIL rnd_rpath c=%0d: got rv m1/m0=%b%b rready=%b want sel=%0d rready=%b", c, m1_rvalid, m0_rvalid, s_rready, sel, exp_rready);
      end
      // Advance the model across the coming rising edge
      done    = s_rvalid && exp_rready && s_rlast;
      err_exp = done && (cnt[sel] == 0);
      if (hold) begin
        if (s_arready) hold = 0;
      end else if (g >= 0) begin
        hold = 1; last = g;
        exp_addr  = (g == 0) ? m0_araddr  : m1_araddr;
        exp_len   = (g == 0) ? m0_arlen   : m1_arlen;
        exp_size  = (g == 0) ? m0_arsize  : m1_arsize;
        exp_burst = (g == 0) ? m0_arburst : m1_arburst;
        exp_id    = (g == 0) ? {1'b0, m0_arid} : {1'b1, m1_arid};
        $display("rnd ar grant c=%0d m%0d addr=%h id=%h", c, g, exp_addr, exp_id);
      end
      if (g >= 0 && !(done && sel == g)) cnt[g]++;
      if (done && !(g == sel) && cnt[sel] > 0) cnt[sel]--;
      @(negedge ACLK);
    end
    idle_inputs();
    $display("test_random done: cnt0=%0d cnt1=%0d", cnt[0], cnt[1]);
  endtask

  initial begin
    ARESET = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_alternate();
    test_hold_stall();
    test_limit();
    test_r_steer();
    test_unexp_r();
    test_reset_in_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
